rx_frame_fifo: RTL and testbench
================================

# rx_frame_fifo

Store-and-forward receive frame buffer directly downstream of the receive MAC. It accepts the MAC's non-backpressurable AXIS stream and holds each frame until its `tlast` beat. Frames are released to a backpressured AXIS master only when the MAC flags a good FCS (`tuser=1`); bad-FCS and overflowed frames are discarded by rolling back the write pointer. It also folds the MAC's empty terminate beat (`tlast` with `tkeep=0`) into the preceding beat, so no zero-keep beats leave the block.

## Interface
- `DATA_WIDTH`, 32, data width; only 32 is supported.
- `DEPTH`, 512, buffer depth in words; must be a power of two, minimum 16.
- `i_clk` input 1: the block's single clock.
- `i_reset` input 1: asynchronous reset, active-high. One clock; reset is asynchronous and active-high.
- `s00_axis_tdata` input 32: MAC data.
- `s00_axis_tkeep` input 4: byte enables.
- `s00_axis_tvalid` input 1: beat valid. There is no `tready`; every valid beat must be consumed.
- `s00_axis_tlast` input 1: last beat of the frame.
- `s00_axis_tuser` input 1: FCS good; meaningful only with `tlast`.
- `m00_axis_tdata` output 32.
- `m00_axis_tkeep` output 4.
- `m00_axis_tvalid` output 1.
- `m00_axis_tready` input 1.
- `m00_axis_tlast` output 1.
- `o_drop_bad_count` output 16: frames dropped for `tuser=0`, or runt. Saturating.
- `o_drop_ovf_count` output 16: frames dropped because the buffer was full. Saturating.

## Operation
- **Storage:** each memory entry holds {tlast, tkeep[3:0], tdata[31:0]}, 37 bits.
- **Pointers:** `wr_ptr` (speculative), `wr_commit` and `rd_ptr`, each log2(DEPTH)+1 bits and wrapping naturally.
  - Full: `wr_ptr - rd_ptr == DEPTH`.
  - Committed data available: `rd_ptr != wr_commit`.
- **Hold register:** each input beat is staged in a one-entry hold register and written to memory when the next beat arrives. This lets the block rewrite `tlast`.
- **Write FSM states:** IDLE, FRAME, DISCARD, FINISH.
  - **IDLE**
    - Valid beat with `tkeep != 0` and no `tlast`: load hold and go to FRAME.
    - Valid beat with `tlast`: runt. Discard it, increment `o_drop_bad_count`, stay in IDLE.
  - **FRAME**, valid beat without `tlast`:
    - Write hold to memory and increment `wr_ptr`.
    - Hold ← beat.
  - **FRAME**, `tlast` beat with `tkeep != 0`:
    - Write hold to memory and increment `wr_ptr`.
    - Hold ← beat with tlast=1.
    - Latch `tuser` and go to FINISH.
  - **FRAME**, `tlast` beat with `tkeep == 0`:
    - Write hold to memory with its tlast forced to 1, and increment `wr_ptr`.
    - The input beat itself is not stored.
    - Latch `tuser` and go to FINISH with the hold marked empty.
  - **FINISH**, always one cycle:
    - If hold is non-empty, write it and increment `wr_ptr`.
    - Then, if latched tuser=1, set `wr_commit` to the new `wr_ptr`. Otherwise set `wr_ptr` to `wr_commit` and increment `o_drop_bad_count`.
    - Go to IDLE.
  - **Overflow:** any memory write attempted while full is suppressed. `wr_ptr` is set to `wr_commit` and the FSM goes to DISCARD. If the overflowing beat has `tlast`, go to IDLE instead. `o_drop_ovf_count` is incremented once per frame.
  - **DISCARD:** ignore beats until a `tlast` beat, then go to IDLE.
- **Upstream gap guarantee:** the MAC always leaves at least 2 non-valid cycles after `tlast`, because the SFD beat and the preamble-only beat carry no data. A valid beat arriving in FINISH is therefore a protocol violation. Treat it as FRAME-state input after the FINISH actions complete.
- **Read side:**
  - Two-stage prefetch: memory read register feeding the output register.
  - Sustains one beat per cycle while `m00_axis_tready=1`.
  - Outputs hold steady while `tvalid && !tready`.
  - Reads never pass `wr_commit`.
- **Counters:** saturate at 16'hFFFF.

## Timing
- **Reset:** on `i_reset`, all of the following are 0 immediately (asynchronous assertion): pointers, FSM state (IDLE), hold register, prefetch stages, `m00_axis_*` outputs, and both counters.
  - A frame in progress when reset asserts is lost.
  - Reset mid-output drops the remaining words.
- **Commit timing:** `wr_commit` updates at the end of the FINISH cycle, which is cycle t+1 after the `tlast` beat at cycle t.
- **Latency:** with the output idle and the buffer otherwise empty, the first word of the committed frame has `m00_axis_tvalid=1` at cycle t+3.
- **Pointer crossings:** commit and read in the same cycle are both honoured. Full is evaluated on the pre-update `rd_ptr`, so a read in the same cycle does not unblock a write.
- **Throughput:** input runs at up to 1 beat/cycle, and output reaches 1 beat/cycle once primed.

## Test plan
- **Good frame:** 16-beat frame, data 0x00000001..0x00000010, last tkeep=4'b0111, tuser=1. Output carries identical data; last tkeep=4'b0111 with tlast; first tvalid 3 cycles after input tlast.
- **Bad FCS:** the same frame with tuser=0. No output beats; `o_drop_bad_count`=1; the next good frame is output intact.
- **Zero-keep terminate:** 5 beats, with the 5th beat tlast and tkeep=4'b0000. Output is 4 beats; beat 4 has tkeep=4'hF and tlast=1.
- **Overflow:** DEPTH=16, tready=0, send a 12-beat good frame then a 10-beat frame. First frame is kept; second is dropped; `o_drop_ovf_count`=1. After raising tready, exactly 12 beats are output.
- **Backpressure:** three back-to-back good frames with tready toggling pseudo-randomly. Every byte is delivered in order, outputs stay stable while stalled, and there are no zero-keep beats.
- **Reset mid-frame:** assert `i_reset` after 3 input beats, then send a good frame. Only the second frame is output, and both counters read 0.

Source files
------------

// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive frame buffer behind the MAC. Good-FCS frames are forwarded; bad, runt and overflowed frames are dropped.
// Latency: the first word of a committed frame is valid 3 cycles after its input tlast beat (output idle, buffer empty).
// Backpressure: none on the input (every valid beat is consumed); output is AXIS valid/ready and holds steady while stalled.
//
// Ports:
//   i_clk, i_reset          single clock, asynchronous active-high reset
//   s00_axis_*              MAC stream (tdata/tkeep/tvalid/tlast/tuser), no tready
//   m00_axis_*              backpressured frame stream (tdata/tkeep/tvalid/tready/tlast)
//   o_drop_bad_count        saturating count of frames dropped for bad FCS or runt
//   o_drop_ovf_count        saturating count of frames dropped for buffer overflow
module rx_frame_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tkeep,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  input  logic                    s00_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tkeep,
  output logic                    m00_axis_tvalid,
  input  logic                    m00_axis_tready,
  output logic                    m00_axis_tlast,
  output logic [15:0]             o_drop_bad_count,
  output logic [15:0]             o_drop_ovf_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KW + 1;   // {tlast, tkeep, tdata}
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_DISCARD, ST_FINISH} wr_state_e;

  wr_state_e      state_q, state_d;
  logic [EW-1:0]  hold_q, hold_d;
  logic           hold_vld_q, hold_vld_d;
  logic           tuser_q, tuser_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    wr_commit_q, wr_commit_d;
  logic [AW:0]    rd_ptr_q;
  logic [15:0]    bad_cnt_q, ovf_cnt_q;
  logic [EW-1:0]  rd_dat_q, out_dat_q;
  logic           rd_vld_q, out_vld_q;

  logic [EW-1:0]  mem [DEPTH];
  logic           mem_we;
  logic [EW-1:0]  mem_wdat;
  logic           bad_inc, ovf_inc;
  logic [EW-1:0]  beat;
  logic           full;
  logic [AW:0]    ptr_fin;
  logic           out_rdy, s1_rdy, rd_en;

  assign beat    = {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
  // Full uses the pre-update read pointer: a read this cycle cannot unblock a write.
  assign full    = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign ptr_fin = wr_ptr_q + {{AW{1'b0}}, hold_vld_q};

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    tuser_d     = tuser_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    mem_we      = 1'b0;
    mem_wdat    = hold_q;
    bad_inc     = 1'b0;
    ovf_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s00_axis_tvalid) begin
          if (s00_axis_tlast) begin
            bad_inc = 1'b1;                        // single-beat runt
          end else if (s00_axis_tkeep != '0) begin
            hold_d     = beat;
            hold_vld_d = 1'b1;
            state_d    = ST_FRAME;
          end
        end
      end
      ST_FRAME: begin
        if (s00_axis_tvalid) begin
          if (full) begin
            wr_ptr_d   = wr_commit_q;
            hold_vld_d = 1'b0;
            ovf_inc    = 1'b1;
            state_d    = s00_axis_tlast ? ST_IDLE : ST_DISCARD;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (!s00_axis_tlast) begin
              hold_d = beat;
            end else begin
              tuser_d = s00_axis_tuser;
              state_d = ST_FINISH;
              if (s00_axis_tkeep != '0) begin
                hold_d = beat;
              end else begin
                // Empty terminate beat: fold tlast into the held word.
                mem_wdat[EW-1] = 1'b1;
                hold_vld_d     = 1'b0;
              end
            end
          end
        end
      end
      ST_DISCARD: begin
        if (s00_axis_tvalid && s00_axis_tlast) state_d = ST_IDLE;
      end
      ST_FINISH: begin
        state_d    = ST_IDLE;
        hold_vld_d = 1'b0;
        if (hold_vld_q && full) begin
          wr_ptr_d = wr_commit_q;
          ovf_inc  = 1'b1;
        end else begin
          mem_we = hold_vld_q;
          if (tuser_q) begin
            wr_commit_d = ptr_fin;
            wr_ptr_d    = ptr_fin;
          end else begin
            wr_ptr_d = wr_commit_q;
            bad_inc  = 1'b1;
          end
        end
        // A beat here breaks the MAC's idle-gap guarantee; start a new frame with it.
        if (s00_axis_tvalid && !s00_axis_tlast && s00_axis_tkeep != '0) begin
          hold_d     = beat;
          hold_vld_d = 1'b1;
          state_d    = ST_FRAME;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= mem_wdat;
  end

  // Read pipeline: memory read register -> output register.
  // Availability looks at the next commit value so the first read overlaps the
  // FINISH cycle. The word written during FINISH is never the one read then: a
  // committed frame always has an earlier word at or after rd_ptr.
  assign out_rdy = !out_vld_q || m00_axis_tready;
  assign s1_rdy  = !rd_vld_q || out_rdy;
  assign rd_en   = (rd_ptr_q != wr_commit_d) && s1_rdy;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      tuser_q     <= 1'b0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      bad_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
      rd_dat_q    <= '0;
      rd_vld_q    <= 1'b0;
      out_dat_q   <= '0;
      out_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      tuser_q     <= tuser_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      if (bad_inc && bad_cnt_q != 16'hFFFF) bad_cnt_q <= bad_cnt_q + 1'b1;
      if (ovf_inc && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 1'b1;
      if (rd_en) begin
        rd_dat_q <= mem[rd_ptr_q[AW-1:0]];
        rd_vld_q <= 1'b1;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end else if (out_rdy) begin
        rd_vld_q <= 1'b0;
      end
      if (out_rdy) begin
        out_vld_q <= rd_vld_q;
        out_dat_q <= rd_dat_q;
      end
    end
  end

  assign m00_axis_tdata   = out_dat_q[DATA_WIDTH-1:0];
  assign m00_axis_tkeep   = out_dat_q[DATA_WIDTH+KW-1:DATA_WIDTH];
  assign m00_axis_tlast   = out_dat_q[EW-1];
  assign m00_axis_tvalid  = out_vld_q;
  assign o_drop_bad_count = bad_cnt_q;
  assign o_drop_ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Bench for rx_frame_fifo: a DEPTH=512 instance and a DEPTH=16 instance share the input stream.
// Expected beats are queued as frames are driven and popped as the outputs hand off.
module tb_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_dat = '0;
  logic [3:0]  s_keep = '0;
  logic        s_vld = 1'b0;
  logic        s_last = 1'b0;
  logic        s_user = 1'b0;

  logic [31:0] m_dat, m16_dat;
  logic [3:0]  m_keep, m16_keep;
  logic        m_vld, m16_vld, m_last, m16_last;
  logic        m_rdy = 1'b1;
  logic        rdy16 = 1'b1;
  logic [15:0] bad_cnt, ovf_cnt, bad16, ovf16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_last = 0;
  int n16 = 0;
  logic bp_en = 1'b0;
  logic rdy_fix = 1'b1;
  logic mon16_en = 1'b0;
  logic [36:0] sbq[$];
  logic [36:0] q16[$];

  rx_frame_fifo #(.DATA_WIDTH(32), .DEPTH(512)) dut (
    .i_clk(clk), .i_reset(rst),
    .s00_axis_tdata(s_dat), .s00_axis_tkeep(s_keep), .s00_axis_tvalid(s_vld),
    .s00_axis_tlast(s_last), .s00_axis_tuser(s_user),
    .m00_axis_tdata(m_dat), .m00_axis_tkeep(m_keep), .m00_axis_tvalid(m_vld),
    .m00_axis_tready(m_rdy), .m00_axis_tlast(m_last),
    .o_drop_bad_count(bad_cnt), .o_drop_ovf_count(ovf_cnt)
  );

  rx_frame_fifo #(.DATA_WIDTH(32), .DEPTH(16)) dut16 (
    .i_clk(clk), .i_reset(rst),
    .s00_axis_tdata(s_dat), .s00_axis_tkeep(s_keep), .s00_axis_tvalid(s_vld),
    .s00_axis_tlast(s_last), .s00_axis_tuser(s_user),
    .m00_axis_tdata(m16_dat), .m00_axis_tkeep(m16_keep), .m00_axis_tvalid(m16_vld),
    .m00_axis_tready(rdy16), .m00_axis_tlast(m16_last),
    .o_drop_bad_count(bad16), .o_drop_ovf_count(ovf16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_rdy = bp_en ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output monitor for the main instance.
  logic        prev_stall = 1'b0;
  logic [36:0] prev_beat = '0;
  always @(negedge clk) begin
    logic [36:0] obs, exp_b;
    obs = {m_last, m_keep, m_dat};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_vld || obs !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got vld=%0b beat=%h want vld=1 beat=%h", m_vld, obs, prev_beat);
        end
      end
      if (m_vld) begin
        checks++;
        if (m_keep === 4'h0) begin
          errors++;
          $display("FAIL zero_keep_out: got keep=%h want nonzero", m_keep);
        end
      end
      if (m_vld && m_rdy) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h want no beat", obs);
        end else begin
          exp_b = sbq.pop_front();
          if (obs !== exp_b) begin
            errors++;
            $display("FAIL out_beat: got %h want %h", obs, exp_b);
          end
        end
      end
      prev_stall = m_vld && !m_rdy;
      prev_beat  = obs;
    end
  end

  // Output monitor for the DEPTH=16 instance, active only in the overflow scenario.
  always @(negedge clk) begin
    logic [36:0] obs, exp_b;
    obs = {m16_last, m16_keep, m16_dat};
    if (!rst && mon16_en && m16_vld && rdy16) begin
      n16++;
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat16: got %h want no beat", obs);
      end else begin
        exp_b = q16.pop_front();
        if (obs !== exp_b) begin
          errors++;
          $display("FAIL out_beat16: got %h want %h", obs, exp_b);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    q16.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drives n beats; zt makes the last beat an empty terminate beat. Good frames
  // of two or more beats are queued in their expected (folded) form.
  task automatic send_frame(input int n, input logic [31:0] base, input logic [3:0] lk,
                            input logic tu, input logic zt, input logic p16, input logic rnd);
    logic [31:0] d;
    logic [36:0] e;
    logic        push;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      d      = rnd ? 32'($urandom) : base + 32'(i);
      s_dat  = d;
      s_vld  = 1'b1;
      s_last = (i == n - 1);
      s_keep = (i == n - 1) ? (zt ? 4'h0 : lk) : 4'hF;
      s_user = (i == n - 1) ? tu : 1'b0;
      if (i == n - 1) t_last = cyc;
      push = 1'b0;
      e    = '0;
      if (tu && n >= 2) begin
        if (!zt) begin
          push = 1'b1;
          e    = (i == n - 1) ? {1'b1, lk, d} : {1'b0, 4'hF, d};
        end else if (i <= n - 2) begin
          push = 1'b1;
          e    = {(i == n - 2), 4'hF, d};
        end
      end
      if (push) begin
        sbq.push_back(e);
        if (p16) q16.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    s_vld  = 1'b0;
    s_last = 1'b0;
    s_keep = 4'h0;
    s_user = 1'b0;
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && (sbq.size() != 0 || q16.size() != 0); i++) @(negedge clk);
    idle(8);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats left want 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b want 0", m_vld); end
    checks++; if ({m_last, m_keep, m_dat} !== 37'h0) begin errors++; $display("FAIL rst_data: got %h want 0", {m_last, m_keep, m_dat}); end
    checks++; if (bad_cnt !== 16'h0 || ovf_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h/%h want 0/0", bad_cnt, ovf_cnt); end
    checks++; if (m16_vld !== 1'b0) begin errors++; $display("FAIL rst_vld16: got %b want 0", m16_vld); end
    #1 rst = 1'b0;
    idle(5);
    @(negedge clk);
    checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b want 0", m_vld); end
  endtask

  task automatic test_good_frame();
    logic found;
    found = 1'b0;
    send_frame(16, 32'h1, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_vld) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || (cyc - t_last) != 3) begin
      errors++;
      $display("FAIL latency: got %0d cycles (found=%0b) want 3", cyc - t_last, found);
    end
    drain(200);
  endtask

  task automatic test_bad_fcs();
    send_frame(16, 32'h1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    checks++; if (bad_cnt !== 16'd1) begin errors++; $display("FAIL bad_count: got %0d want 1", bad_cnt); end
    send_frame(1, 32'hAA, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    checks++; if (bad_cnt !== 16'd2) begin errors++; $display("FAIL runt_count: got %0d want 2", bad_cnt); end
    send_frame(6, 32'h200, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(200);
    checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL bad_ovf_count: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_async_reset();
    logic found;
    found = 1'b0;
    rdy_fix = 1'b0;
    send_frame(4, 32'h300, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_vld) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL stalled_vld: got 0 want 1"); end
    rst = 1'b1;
    #1;
    checks++; if (m_vld !== 1'b0 || {m_last, m_keep, m_dat} !== 37'h0) begin errors++; $display("FAIL async_out: got vld=%b beat=%h want 0", m_vld, {m_last, m_keep, m_dat}); end
    checks++; if (bad_cnt !== 16'h0) begin errors++; $display("FAIL async_cnt: got %0d want 0", bad_cnt); end
    sbq.delete();
    q16.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_fix = 1'b1;
    idle(10);
  endtask

  task automatic test_zero_keep();
    send_frame(5, 32'h100, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(200);
  endtask

  task automatic test_overflow();
    do_reset();
    mon16_en = 1'b1;
    n16 = 0;
    rdy16 = 1'b0;
    send_frame(12, 32'h400, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    send_frame(10, 32'h500, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    checks++; if (ovf16 !== 16'd1) begin errors++; $display("FAIL ovf_count: got %0d want 1", ovf16); end
    checks++; if (bad16 !== 16'd0) begin errors++; $display("FAIL ovf_bad_count: got %0d want 0", bad16); end
    checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL deep_ovf_count: got %0d want 0", ovf_cnt); end
    #1 rdy16 = 1'b1;
    drain(300);
    checks++; if (n16 != 12 || q16.size() != 0) begin errors++; $display("FAIL ovf_beats: got %0d want 12", n16); end
    mon16_en = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bp_en = 1'b1;
    send_frame(7, 32'h0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    send_frame(9, 32'h0, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    send_frame(5, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    drain(600);
    bp_en = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      s_dat = 32'hDEAD0000 + 32'(i); s_keep = 4'hF; s_vld = 1'b1; s_last = 1'b0; s_user = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    s_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(4, 32'h600, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(200);
    checks++; if (bad_cnt !== 16'd0 || ovf_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d/%0d want 0/0", bad_cnt, ovf_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_async_reset();
    test_zero_keep();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
